// File: rtl/el2_ifu_ic_dbg_seq.sv
// el2_ifu_ic_dbg_seq: sequences one debug access at a time into the I-cache array debug port,
// waiting out fetch ownership and returning read data, ECC/parity status or a timeout.
module el2_ifu_ic_dbg_seq #(
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_dbg_req_valid,
  output logic        io_dbg_req_ready,
  input  logic        io_dbg_req_wr,
  input  logic        io_dbg_req_tag,
  input  logic [14:0] io_dbg_req_addr,
  input  logic [1:0]  io_dbg_req_way,
  input  logic [70:0] io_dbg_req_wdata,
  output logic        io_dbg_rsp_valid,
  input  logic        io_dbg_rsp_ready,
  output logic [70:0] io_dbg_rsp_data,
  output logic        io_dbg_rsp_err,
  output logic        io_dbg_rsp_timeout,
  input  logic        io_ic_busy,
  output logic [14:0] io_ic_debug_addr,
  output logic        io_ic_debug_rd_en,
  output logic        io_ic_debug_wr_en,
  output logic        io_ic_debug_tag_array,
  output logic [1:0]  io_ic_debug_way,
  output logic [70:0] io_ic_debug_wr_data,
  input  logic [70:0] io_ic_debug_rd_data,
  input  logic [1:0]  io_ic_eccerr,
  input  logic [1:0]  io_ic_parerr
);
  typedef enum logic [2:0] {IDLE, WAIT, ISSUE, RDWAIT, RESP} state_t;
  state_t      state_q, state_d;
  logic        wr_q, wr_d, tag_q, tag_d, err_q, err_d, tmo_q, tmo_d;
  logic [14:0] addr_q, addr_d;
  logic [1:0]  way_q, way_d;
  logic [70:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [2:0]  lcnt_q, lcnt_d;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      tag_q   <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      addr_q  <= '0;
      way_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wcnt_q  <= '0;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      way_q   <= way_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wcnt_q  <= wcnt_d;
      lcnt_q  <= lcnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    tag_d   = tag_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    addr_d  = addr_q;
    way_d   = way_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wcnt_d  = wcnt_q;
    lcnt_d  = lcnt_q;
    case (state_q)
      IDLE: if (io_dbg_req_valid) begin
        wr_d    = io_dbg_req_wr;
        tag_d   = io_dbg_req_tag;
        addr_d  = io_dbg_req_addr;
        way_d   = io_dbg_req_way;
        wdata_d = io_dbg_req_wdata;
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: if (!io_ic_busy) state_d = ISSUE;
      else begin
        wcnt_d = (wcnt_q == 8'hFF) ? wcnt_q : wcnt_q + 8'd1;
        if (wcnt_d >= 8'(MAX_WAIT)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = RESP;
        end
      end
      ISSUE: begin
        rdata_d = '0;
        err_d   = 1'b0;
        tmo_d   = 1'b0;
        lcnt_d  = 3'(RD_LAT - 1);
        state_d = wr_q ? RESP : RDWAIT;
      end
      RDWAIT: if (lcnt_q == '0) begin
        // Tag array has no ECC, so only parity counts there
        rdata_d = io_ic_debug_rd_data;
        err_d   = tag_q ? |io_ic_parerr : (|io_ic_eccerr | |io_ic_parerr);
        state_d = RESP;
      end else lcnt_d = lcnt_q - 3'd1;
      RESP: if (io_dbg_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign io_dbg_req_ready      = state_q == IDLE;
  assign io_dbg_rsp_valid      = state_q == RESP;
  assign io_dbg_rsp_data       = rdata_q;
  assign io_dbg_rsp_err        = err_q;
  assign io_dbg_rsp_timeout    = tmo_q;
  assign io_ic_debug_addr      = addr_q;
  assign io_ic_debug_way       = way_q;
  assign io_ic_debug_tag_array = tag_q;
  assign io_ic_debug_wr_data   = wdata_q;
  assign io_ic_debug_rd_en     = (state_q == ISSUE) && !wr_q;
  assign io_ic_debug_wr_en     = (state_q == ISSUE) && wr_q;
endmodule

// File: tb/tb_el2_ifu_ic_dbg_seq.sv
// tb_el2_ifu_ic_dbg_seq: directed and randomized transactions checked against a
// transaction-level timing/result model of the debug sequencer.
module tb_el2_ifu_ic_dbg_seq;
  localparam int RD_LAT   = 3;
  localparam int MAX_WAIT = 20;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr, req_tag;
  logic [14:0] req_addr;
  logic [1:0]  req_way;
  logic [70:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_tmo;
  logic [70:0] rsp_data;
  logic        busy, rd_en, wr_en, dbg_tag;
  logic [14:0] dbg_addr;
  logic [1:0]  dbg_way, eccerr, parerr;
  logic [70:0] dbg_wdata, rd_data;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  el2_ifu_ic_dbg_seq #(.RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .clock(clk), .reset(rst),
    .io_dbg_req_valid(req_valid), .io_dbg_req_ready(req_ready), .io_dbg_req_wr(req_wr),
    .io_dbg_req_tag(req_tag), .io_dbg_req_addr(req_addr), .io_dbg_req_way(req_way),
    .io_dbg_req_wdata(req_wdata), .io_dbg_rsp_valid(rsp_valid), .io_dbg_rsp_ready(rsp_ready),
    .io_dbg_rsp_data(rsp_data), .io_dbg_rsp_err(rsp_err), .io_dbg_rsp_timeout(rsp_tmo),
    .io_ic_busy(busy), .io_ic_debug_addr(dbg_addr), .io_ic_debug_rd_en(rd_en),
    .io_ic_debug_wr_en(wr_en), .io_ic_debug_tag_array(dbg_tag), .io_ic_debug_way(dbg_way),
    .io_ic_debug_wr_data(dbg_wdata), .io_ic_debug_rd_data(rd_data),
    .io_ic_eccerr(eccerr), .io_ic_parerr(parerr)
  );
  task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err_tmo", {rsp_err, rsp_tmo}, 0);
    chk("rst_enables", {rd_en, wr_en}, 0);
    chk("rst_addr_way_tag", {dbg_addr, dbg_way, dbg_tag}, 0);
    chk("rst_wr_data", dbg_wdata, 0);
  endtask
  function automatic logic [70:0] rnd71();
    return 71'({$urandom(), $urandom(), $urandom()});
  endfunction
  // One request: nbusy cycles of fetch ownership in WAIT, rsp_ready withheld hold cycles.
  task automatic txn(input logic wr, input logic tag, input logic [14:0] a, input logic [1:0] w,
                     input logic [70:0] wd, input int nbusy, input int hold, input logic keep,
                     input logic [70:0] rd, input logic [1:0] ecc, input logic [1:0] par);
    bit tmo = nbusy >= MAX_WAIT;
    int t_iss = nbusy + 1;
    int t_rsp = tmo ? MAX_WAIT : t_iss + (wr ? 1 : RD_LAT + 1);
    int t_cap = t_iss + RD_LAT;
    logic [70:0] exp_data = (tmo || wr) ? '0 : rd;
    logic exp_err = tmo ? 1'b1 : wr ? 1'b0 : tag ? |par : (|ecc || |par);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    chk("rsp_valid_idle", rsp_valid, 0);
    req_valid = 1'b1; req_wr = wr; req_tag = tag; req_addr = a; req_way = w; req_wdata = wd;
    rsp_ready = 1'b0;
    busy = nbusy > 0;
    for (int c = 0; c <= t_rsp + hold; c++) begin
      @(negedge clk);
      chk("req_ready_held", req_ready, 0);
      chk("enables", {rd_en, wr_en}, (!tmo && c == t_iss) ? {!wr, wr} : 2'b00);
      if (!tmo && c == t_iss) begin
        chk("issue_addr", dbg_addr, a);
        chk("issue_way_tag", {dbg_way, dbg_tag}, {w, tag});
        chk("issue_wdata", dbg_wdata, wd);
      end
      chk("rsp_valid", rsp_valid, c >= t_rsp);
      if (c >= t_rsp) begin
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_timeout", rsp_tmo, tmo);
      end
      req_valid = keep;
      busy = (c < nbusy) ? 1'b1 : (c > nbusy) ? 1'($urandom_range(0, 1)) : 1'b0;
      rd_data = (c == t_cap) ? rd : rnd71();
      eccerr = (c == t_cap) ? ecc : 2'($urandom);
      parerr = (c == t_cap) ? par : 2'($urandom);
      rsp_ready = (c >= t_rsp + hold) ? 1'b1 : (c < t_rsp) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask
  initial begin
    req_valid = 0; req_wr = 0; req_tag = 0; req_addr = '0; req_way = '0; req_wdata = '0;
    rsp_ready = 0; busy = 0; rd_data = '0; eccerr = '0; parerr = '0;
    rst = 1'b1;
    #1 chk_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    txn(0, 0, 15'h012, 2'd1, rnd71(), 0, 0, 0, 71'h1_2345_6789_ABCD_EF01, 2'b00, 2'b00);
    txn(1, 0, 15'h0A5, 2'd2, {71{1'b1}}, 0, 0, 0, rnd71(), 2'b00, 2'b00);
    txn(0, 0, 15'h100, 2'd0, rnd71(), 0, 0, 0, rnd71(), 2'b10, 2'b00);
    txn(0, 1, 15'h100, 2'd0, rnd71(), 0, 0, 0, rnd71(), 2'b10, 2'b00);
    txn(0, 1, 15'h101, 2'd3, rnd71(), 0, 1, 0, rnd71(), 2'b00, 2'b01);
    txn(0, 0, 15'h7FFF, 2'd3, rnd71(), 10, 0, 0, rnd71(), 2'b00, 2'b00);
    txn(1, 0, 15'h055, 2'd1, rnd71(), MAX_WAIT - 1, 0, 0, rnd71(), 2'b00, 2'b00);
    txn(0, 0, 15'h056, 2'd2, rnd71(), MAX_WAIT, 0, 0, rnd71(), 2'b00, 2'b00);
    txn(1, 1, 15'h057, 2'd0, rnd71(), MAX_WAIT + 5, 2, 0, rnd71(), 2'b00, 2'b00);
    txn(0, 0, 15'h2AA, 2'd1, rnd71(), 0, 5, 1, 71'h0F_0F0F_0F0F_0F0F_0F0F, 2'b00, 2'b00);
    txn(0, 0, 15'h2AA, 2'd1, rnd71(), 0, 0, 0, 71'h55_5555_5555_5555_5555, 2'b00, 2'b00);
    for (int i = 0; i < 40; i++) begin
      int sel, nb;
      sel = $urandom_range(0, 9);
      nb = (sel < 5) ? 0 : (sel < 8) ? $urandom_range(1, 6) : (sel == 8) ? MAX_WAIT - 1 : MAX_WAIT + $urandom_range(0, 2);
      txn(1'($urandom), 1'($urandom), 15'($urandom), 2'($urandom), rnd71(), nb,
          $urandom_range(0, 3), $urandom_range(0, 3) == 0, rnd71(),
          ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00,
          ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00);
    end
    @(negedge clk);
    chk("mid_req_ready", req_ready, 1);
    req_valid = 1; req_wr = 0; req_tag = 0; req_addr = 15'h321; req_way = 2'd3; req_wdata = rnd71();
    busy = 0; rsp_ready = 1;
    @(negedge clk) req_valid = 0;
    @(negedge clk) chk("mid_rd_en", rd_en, 1);
    @(negedge clk) chk("mid_rdwait_quiet", {rd_en, wr_en, rsp_valid}, 0);
    #1 rst = 1'b1;
    #1 chk_reset();
    @(negedge clk) rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_no_rsp", rsp_valid, 0);
      chk("post_rst_ready", req_ready, 1);
      chk("post_rst_enables", {rd_en, wr_en}, 0);
    end
    txn(0, 1, 15'h444, 2'd2, rnd71(), 2, 1, 0, rnd71(), 2'b11, 2'b10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
